// File: rtl/gf_mul_const_pipe.sv
// Multi-lane GF(2^8) multiply-by-constant for (inverse) MixColumns: two register stages,
// valid/ready stream with backpressure, and a sticky flag for reserved coefficient selects.
module gf_mul_const_pipe #(
  parameter int         LANES = 4,
  parameter logic [7:0] POLY  = 8'h1B
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [8*LANES-1:0]   In_Data,
  input  logic [2:0]           Coef_Sel,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [8*LANES-1:0]   Out_Data,
  output logic                 Err,
  input  logic                 Err_Clr
);

  localparam logic [2:0] SEL_RSV = 3'd7;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  // Every supported constant is an XOR of the doubling chain 1, 2, 4, 8.
  function automatic logic [7:0] coef_mix(input logic [2:0] sel, input logic [7:0] x1,
                                          input logic [7:0] x2, input logic [7:0] x4,
                                          input logic [7:0] x8);
    logic [7:0] r;
    case (sel)
      3'd0:    r = x1;
      3'd1:    r = x2;
      3'd2:    r = x2 ^ x1;
      3'd3:    r = x8 ^ x1;
      3'd4:    r = x8 ^ x2 ^ x1;
      3'd5:    r = x8 ^ x4 ^ x1;
      3'd6:    r = x8 ^ x4 ^ x2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic                  adv1, adv2, accept;
  logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic                  err_q, err_d;
  logic [LANES-1:0][7:0] s1_x1_q, s1_x2_q, s1_x4_q, s1_x8_q;
  logic [LANES-1:0][7:0] s1_x1_d, s1_x2_d, s1_x4_d, s1_x8_d;
  logic [2:0]            s1_sel_q;
  logic [LANES-1:0][7:0] s2_data_q, s2_data_d;

  // Flow control: a stage may load when it is empty or its contents move on this edge.
  always_comb begin
    adv2     = !s2_vld_q || Out_Ready;
    adv1     = !s1_vld_q || adv2;
    In_Ready = adv1 && !RST;
    accept   = In_Valid && In_Ready;
    s1_vld_d = adv1 ? accept : s1_vld_q;
    s2_vld_d = adv2 ? s1_vld_q : s2_vld_q;
    err_d    = err_q;
    if (Err_Clr) err_d = 1'b0;
    if (accept && (Coef_Sel == SEL_RSV)) err_d = 1'b1;
  end

  always_comb begin
    s1_x1_d   = '0;
    s1_x2_d   = '0;
    s1_x4_d   = '0;
    s1_x8_d   = '0;
    s2_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_x1_d[i]   = In_Data[8*i +: 8];
      s1_x2_d[i]   = xtime(s1_x1_d[i]);
      s1_x4_d[i]   = xtime(s1_x2_d[i]);
      s1_x8_d[i]   = xtime(s1_x4_d[i]);
      s2_data_d[i] = coef_mix(s1_sel_q, s1_x1_q[i], s1_x2_q[i], s1_x4_q[i], s1_x8_q[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      err_q    <= err_d;
    end
  end

  // Stage 1: doubling chain and coefficient select.
  always_ff @(posedge CLK) begin
    if (adv1) begin
      s1_x1_q  <= s1_x1_d;
      s1_x2_q  <= s1_x2_d;
      s1_x4_q  <= s1_x4_d;
      s1_x8_q  <= s1_x8_d;
      s1_sel_q <= Coef_Sel;
    end
  end

  // Stage 2: selected product.
  always_ff @(posedge CLK) begin
    if (adv2) s2_data_q <= s2_data_d;
  end

  assign Out_Valid = s2_vld_q;
  assign Out_Data  = s2_vld_q ? s2_data_q : '0;
  assign Err       = err_q;

endmodule

// File: tb/tb_gf_mul_const_pipe.sv
// Directed and randomised checks of gf_mul_const_pipe with 16 lanes against hand-computed
// products and an independent shift-and-add GF(2^8) reference.
module tb_gf_mul_const_pipe;

  localparam int L = 16;

  logic           CLK = 1'b0;
  logic           RST;
  logic           In_Valid;
  logic           In_Ready;
  logic [8*L-1:0] In_Data;
  logic [2:0]     Coef_Sel;
  logic           Out_Valid;
  logic           Out_Ready;
  logic [8*L-1:0] Out_Data;
  logic           Err;
  logic           Err_Clr;

  int n_chk = 0;
  int n_err = 0;

  gf_mul_const_pipe #(.LANES(L), .POLY(8'h1B)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Coef_Sel(Coef_Sel), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Err(Err), .Err_Clr(Err_Clr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Shift-and-add product, independent of the xtime chain.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [2:0] sel);
    logic [7:0] c, p, m;
    case (sel)
      3'd0: c = 8'h01; 3'd1: c = 8'h02; 3'd2: c = 8'h03; 3'd3: c = 8'h09;
      3'd4: c = 8'h0B; 3'd5: c = 8'h0D; 3'd6: c = 8'h0E; default: c = 8'h00;
    endcase
    p = 8'h00;
    m = a;
    for (int k = 0; k < 8; k++) begin
      if (c[k]) p = p ^ m;
      m = m[7] ? ((m << 1) ^ 8'h1B) : (m << 1);
    end
    return p;
  endfunction

  logic [7:0]     t2_exp [7] = '{8'h0E, 8'h1C, 8'h12, 8'h7E, 8'h62, 8'h46, 8'h54};
  logic [7:0]     t3_exp [6] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C};
  logic [8*L-1:0] sb_q[$];
  logic [8*L-1:0] exp_v;

  initial begin
    int j, r, stall, acc, late;
    bit seen, resume;

    // Test 1: reset state, then a single x2 beat.
    RST = 1'b1; In_Valid = 1'b1; In_Data = {L{8'h57}}; Coef_Sel = 3'd1;
    Out_Ready = 1'b1; Err_Clr = 1'b0;
    tick(); tick();
    check("rst_in_ready", In_Ready, 1'b0);
    check("rst_out_valid", Out_Valid, 1'b0);
    check("rst_out_data", Out_Data, '0);
    check("rst_err", Err, 1'b0);
    RST = 1'b0; In_Valid = 1'b0;
    tick(); tick();
    check("rst_dropped", Out_Valid, 1'b0);

    In_Valid = 1'b1; In_Data = {96'h0, 32'h87_80_FF_57}; Coef_Sel = 3'd1;
    #1 check("t1_in_ready", In_Ready, 1'b1);
    tick();
    In_Valid = 1'b0;
    check("t1_lat1_valid", Out_Valid, 1'b0);
    tick();
    check("t1_valid", Out_Valid, 1'b1);
    check("t1_data", Out_Data, {96'h0, 32'h15_1B_E5_AE});
    tick();
    check("t1_gap_valid", Out_Valid, 1'b0);
    check("t1_gap_data", Out_Data, '0);

    // Test 2: every coefficient on consecutive cycles.
    for (int i = 0; i < 9; i++) begin
      In_Valid = (i < 7); In_Data = {L{8'h0E}}; Coef_Sel = 3'(i);
      tick();
      if (i >= 1 && i <= 7) begin
        check("t2_valid", Out_Valid, 1'b1);
        check($sformatf("t2_sel%0d", i - 1), Out_Data, {L{t2_exp[i-1]}});
      end
    end
    check("t2_end_valid", Out_Valid, 1'b0);

    // Test 3: backpressure with six beats.
    j = 0; r = 0; stall = 0; seen = 0; resume = 0;
    for (int c = 0; c < 30 && r < 6; c++) begin
      In_Valid = (j < 6); In_Data = {L{8'(j + 1)}}; Coef_Sel = 3'd1;
      if (Out_Valid && !seen) begin seen = 1; stall = 4; end
      Out_Ready = (stall == 0);
      #1;
      if (stall > 0) begin
        check("t3_hold_data", Out_Data, {L{t3_exp[0]}});
        check("t3_in_ready_low", In_Ready, 1'b0);
        stall--;
        if (stall == 0) resume = 1;
      end else if (resume) begin
        check("t3_in_ready_rise", In_Ready, 1'b1);
        resume = 0;
      end
      if (In_Valid && In_Ready) j++;
      if (Out_Valid && Out_Ready) begin
        check($sformatf("t3_beat%0d", r), Out_Data, {L{t3_exp[r]}});
        r++;
      end
      tick();
    end
    check("t3_sent", j, 6);
    check("t3_recv", r, 6);
    In_Valid = 1'b0; Out_Ready = 1'b1;
    tick(); tick();
    check("t3_no_dup", Out_Valid, 1'b0);

    // Test 4: reserved select and sticky Err.
    In_Valid = 1'b1; In_Data = {L{8'h57}}; Coef_Sel = 3'd7;
    tick();
    In_Valid = 1'b0;
    check("t4_err_set", Err, 1'b1);
    tick();
    check("t4_rsv_valid", Out_Valid, 1'b1);
    check("t4_rsv_data", Out_Data, '0);
    In_Valid = 1'b1; Err_Clr = 1'b1;
    tick();
    check("t4_set_wins", Err, 1'b1);
    In_Valid = 1'b0;
    tick();
    Err_Clr = 1'b0;
    check("t4_err_clr", Err, 1'b0);
    tick(); tick();

    // Test 5: reset with two beats in flight.
    In_Valid = 1'b1; In_Data = {L{8'h57}}; Coef_Sel = 3'd1;
    tick();
    Coef_Sel = 3'd7;
    tick();
    In_Valid = 1'b0;
    check("t5_pre_valid", Out_Valid, 1'b1);
    check("t5_pre_err", Err, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_valid", Out_Valid, 1'b0);
    check("t5_data", Out_Data, '0);
    check("t5_err", Err, 1'b0);
    late = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Out_Valid) late++;
    end
    check("t5_no_stale", late, 0);

    // Test 6: random traffic against the reference model.
    acc = 0;
    for (int c = 0; c < 60000 && (acc < 10000 || sb_q.size() > 0); c++) begin
      In_Valid = (acc < 10000) && ($urandom_range(0, 3) != 0);
      for (int l = 0; l < L; l++) In_Data[8*l +: 8] = 8'($urandom);
      Coef_Sel = 3'($urandom_range(0, 7));
      Out_Ready = ($urandom_range(0, 3) != 0);
      #1;
      if (Out_Valid && Out_Ready) begin
        if (sb_q.size() == 0) check("t6_spurious", Out_Valid, 1'b0);
        else check("t6_data", Out_Data, sb_q.pop_front());
      end else if (!Out_Valid) begin
        check("t6_gated", Out_Data, '0);
      end
      if (In_Valid && In_Ready) begin
        for (int l = 0; l < L; l++) exp_v[8*l +: 8] = gf_ref(In_Data[8*l +: 8], Coef_Sel);
        sb_q.push_back(exp_v);
        acc++;
      end
      tick();
    end
    check("t6_accepted", acc, 10000);
    check("t6_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
